mul_operand_sequencer: RTL

//  - Upstream feeder for the repeated-addition multiplier datapath/controller pair.
//  - Queues operand pairs arriving on a valid/ready interface in a small FIFO.
//  - Pulses the multiplier's start and drives A, then B, onto its shared data bus
//    in the controller's load slots.
//  - Waits for done, captures the product and returns it on a valid/ready result port.

---
 rtl/mul_operand_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mul_operand_sequencer.sv
// Operand-pair FIFO and load sequencer for the repeated-addition multiplier.
// Optional build macro MUL_SEQ_SWAP_EN: run the smaller operand as iteration count.
module mul_operand_sequencer #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_data,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_prod,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_prod,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD_A,
    LOAD_B,
    WAIT,
    RESP
  } state_t;

  state_t state;

  logic [WIDTH-1:0] fifo_a [FIFO_DEPTH];
  logic [WIDTH-1:0] fifo_b [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic [WIDTH-1:0] pop_a;
  logic [WIDTH-1:0] pop_b;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  assign head_a = fifo_a[rd_ptr];
  assign head_b = fifo_b[rd_ptr];
  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);

  // pop depends only on registered state, so in_ready has no input path
  assign pop      = (state == IDLE) && !empty && !res_valid;
  assign in_ready = !full || pop;
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE) || !empty;

`ifdef MUL_SEQ_SWAP_EN
  logic swap;
  assign swap  = (head_b > head_a);
  assign pop_a = swap ? head_b : head_a;
  assign pop_b = swap ? head_a : head_b;
`else
  assign pop_a = head_a;
  assign pop_b = head_b;
`endif

  // Pair storage; contents are don't-care while the slot is unoccupied
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= in_a;
      fifo_b[wr_ptr] <= in_b;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Job sequencer with registered multiplier and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      mul_start <= 1'b0;
      mul_data  <= '0;
      res_valid <= 1'b0;
      res_prod  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            op_a      <= pop_a;
            op_b      <= pop_b;
            mul_start <= 1'b1;
            mul_data  <= '0;
            state     <= START;
          end
        end
        START: begin
          mul_start <= 1'b0;
          mul_data  <= op_a;
          state     <= LOAD_A;
        end
        LOAD_A: begin
          mul_data <= op_b;
          state    <= LOAD_B;
        end
        LOAD_B: begin
          state <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            res_prod  <= mul_prod;
            res_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
